// File: rtl/hs32_bus16_pkg.sv
// Shared definitions for the hs32 external memory bridge: FSM state
// encodings and the rw polarity used by the CPU and the memory arbiter.
package hs32_bus16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // i_rw value that marks a write cycle
    localparam logic HS32_WRITE = 1'b1;

endpackage

// File: rtl/hs32_bus16.sv
// hs32_bus16: 32-bit CPU memory port to 16-bit async SRAM bus bridge.
// Each word moves as two halfword cycles (low half at the even halfword
// address first), each cycle being SETUP, WAIT x STROBE, HOLD. Every output
// is registered: the output registers are loaded with the values that belong
// to the state being entered, so they line up with the state register.
module hs32_bus16
    import hs32_bus16_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int WAIT   = 2
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic [31:0]       i_addr,
    input  logic              i_rw,
    input  logic [31:0]       i_dtw,
    input  logic              i_valid,
    output logic [31:0]       o_dtr,
    output logic              o_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W = $clog2(WAIT + 1);

    state_t              state, state_nxt;
    logic                half, half_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-2:0]   addr_q, addr_nxt;
    logic                rw_q, rw_nxt;
    logic [31:0]         dtw_q, dtw_nxt;
    logic [15:0]         lo_q, lo_nxt, hi_q, hi_nxt;

    logic [31:0]         dtr_nxt;
    logic                ready_nxt;
    logic [ADDR_W-1:0]   sram_addr_nxt;
    logic [15:0]         dq_o_nxt;
    logic                dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;

    // byte-lane bits and bits above the SRAM space are not decoded (aliasing)
    logic unused_addr;
    assign unused_addr = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};

    // next-state and next-output decode; outputs default to holding
    always_comb begin
        state_nxt     = state;
        half_nxt      = half;
        cnt_nxt       = cnt;
        addr_nxt      = addr_q;
        rw_nxt        = rw_q;
        dtw_nxt       = dtw_q;
        lo_nxt        = lo_q;
        hi_nxt        = hi_q;
        dtr_nxt       = o_dtr;
        ready_nxt     = 1'b0;
        sram_addr_nxt = sram_addr;
        dq_o_nxt      = sram_dq_o;
        dq_oe_nxt     = sram_dq_oe;
        ce_n_nxt      = sram_ce_n;
        oe_n_nxt      = sram_oe_n;
        we_n_nxt      = sram_we_n;

        case (state)
            ST_IDLE: begin
                ce_n_nxt  = 1'b1;
                oe_n_nxt  = 1'b1;
                we_n_nxt  = 1'b1;
                dq_oe_nxt = 1'b0;
                dtr_nxt   = '0;
                if (i_valid) begin
                    addr_nxt      = i_addr[ADDR_W:2];
                    rw_nxt        = i_rw;
                    dtw_nxt       = i_dtw;
                    half_nxt      = 1'b0;
                    state_nxt     = ST_SETUP;
                    sram_addr_nxt = {i_addr[ADDR_W:2], 1'b0};
                    ce_n_nxt      = 1'b0;
                    dq_oe_nxt     = (i_rw == HS32_WRITE);
                    if (i_rw == HS32_WRITE)
                        dq_o_nxt = i_dtw[15:0];
                end
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
                cnt_nxt   = CNT_W'(WAIT - 1);
                if (rw_q == HS32_WRITE)
                    we_n_nxt = 1'b0;
                else
                    oe_n_nxt = 1'b0;
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    oe_n_nxt  = 1'b1;
                    we_n_nxt  = 1'b1;
                    // sample the pad at the end of the strobe window
                    if (rw_q != HS32_WRITE) begin
                        if (half)
                            hi_nxt = sram_dq_i;
                        else
                            lo_nxt = sram_dq_i;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!half) begin
                    half_nxt      = 1'b1;
                    state_nxt     = ST_SETUP;
                    sram_addr_nxt = {addr_q, 1'b1};
                    if (rw_q == HS32_WRITE)
                        dq_o_nxt = dtw_q[31:16];
                end else begin
                    state_nxt = ST_DONE;
                    ready_nxt = 1'b1;
                    dtr_nxt   = (rw_q == HS32_WRITE) ? 32'h0 : {hi_q, lo_q};
                    ce_n_nxt  = 1'b1;
                    dq_oe_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                dtr_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                ce_n_nxt  = 1'b1;
                oe_n_nxt  = 1'b1;
                we_n_nxt  = 1'b1;
                dq_oe_nxt = 1'b0;
            end
        endcase
    end

    // state, datapath and output registers; reset aborts any transfer
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            half       <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            dtw_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            o_dtr      <= '0;
            o_ready    <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= state_nxt;
            half       <= half_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= addr_nxt;
            rw_q       <= rw_nxt;
            dtw_q      <= dtw_nxt;
            lo_q       <= lo_nxt;
            hi_q       <= hi_nxt;
            o_dtr      <= dtr_nxt;
            o_ready    <= ready_nxt;
            sram_addr  <= sram_addr_nxt;
            sram_dq_o  <= dq_o_nxt;
            sram_dq_oe <= dq_oe_nxt;
            sram_ce_n  <= ce_n_nxt;
            sram_oe_n  <= oe_n_nxt;
            sram_we_n  <= we_n_nxt;
        end
    end

endmodule

// File: tb/tb_hs32_bus16.sv
// Bench for hs32_bus16: one instance at WAIT=2/ADDR_W=17 with an SRAM model,
// one at WAIT=1/ADDR_W=10. Bus phases are checked cycle by cycle; read data
// goes through a per-instance scoreboard popped on every o_ready.
module tb_hs32_bus16;

    typedef struct packed {
        logic [4:0]  ctl;   // {ready, ce_n, oe_n, we_n, dq_oe}
        logic [16:0] addr;
        logic [15:0] dq;
    } view_t;

    logic clk, rst;
    int   nchk = 0;
    int   nerr = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    // instance A
    logic [31:0] a_addr_in, a_dtw, a_dtr;
    logic        a_rw, a_valid, a_rdy;
    logic [16:0] a_addr;
    logic [15:0] a_dqo, a_dqi;
    logic        a_dqoe, a_ce, a_oe, a_we;

    // instance B
    logic [31:0] b_addr_in, b_dtw, b_dtr;
    logic        b_rw, b_valid, b_rdy;
    logic [9:0]  b_addr;
    logic [15:0] b_dqo, b_dqi;
    logic        b_dqoe, b_ce, b_oe, b_we;

    view_t va, vb;
    assign va = {{a_rdy, a_ce, a_oe, a_we, a_dqoe}, a_addr, a_dqo};
    assign vb = {{b_rdy, b_ce, b_oe, b_we, b_dqoe}, {7'b0, b_addr}, b_dqo};

    hs32_bus16 #(.ADDR_W(17), .WAIT(2)) dut_a (
        .i_clk(clk), .reset(rst),
        .i_addr(a_addr_in), .i_rw(a_rw), .i_dtw(a_dtw), .i_valid(a_valid),
        .o_dtr(a_dtr), .o_ready(a_rdy),
        .sram_addr(a_addr), .sram_dq_o(a_dqo), .sram_dq_i(a_dqi),
        .sram_dq_oe(a_dqoe), .sram_ce_n(a_ce), .sram_oe_n(a_oe), .sram_we_n(a_we)
    );

    hs32_bus16 #(.ADDR_W(10), .WAIT(1)) dut_b (
        .i_clk(clk), .reset(rst),
        .i_addr(b_addr_in), .i_rw(b_rw), .i_dtw(b_dtw), .i_valid(b_valid),
        .o_dtr(b_dtr), .o_ready(b_rdy),
        .sram_addr(b_addr), .sram_dq_o(b_dqo), .sram_dq_i(b_dqi),
        .sram_dq_oe(b_dqoe), .sram_ce_n(b_ce), .sram_oe_n(b_oe), .sram_we_n(b_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model for A: unwritten locations read as 16'hA000 ^ address
    logic        mem_clr;
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'hA000 ^ 16'(i);
        end else if (!a_ce && !a_we) begin
            mem[a_addr[9:0]] <= a_dqo;
        end
    end
    assign a_dqi = (!a_ce && !a_oe) ? mem[a_addr[9:0]] : 16'h0;
    assign b_dqi = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboards: every completion must match the oldest expected result
    always @(negedge clk) begin
        if (a_rdy === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_ready", 32'd1, 32'd0);
            else chk("a_dtr", a_dtr, qa.pop_front());
        end
        if (b_rdy === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_ready", 32'd1, 32'd0);
            else chk("b_dtr", b_dtr, qb.pop_front());
        end
    end

    // Starts #1 after an edge with the DUT idle; the next edge accepts.
    // abort_at > 0 asserts reset during that cycle instead of completing.
    task automatic xfer(input bit sel, input bit rw, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rexp,
                        input bit keep, input int abort_at);
        int          w, aw, n, h, p;
        logic [31:0] base;
        logic [4:0]  ectl;
        bit          strb;
        view_t       v;
        w    = sel ? 1 : 2;
        aw   = sel ? 10 : 17;
        n    = 2 * (w + 2) + 1;
        base = (addr >> 2) & ((32'd1 << (aw - 1)) - 32'd1);
        if (sel) begin
            b_valid = 1'b1; b_rw = rw; b_addr_in = addr; b_dtw = wd;
        end else begin
            a_valid = 1'b1; a_rw = rw; a_addr_in = addr; a_dtw = wd;
        end
        if (abort_at == 0) begin
            if (sel) qb.push_back(rw ? 32'h0 : rexp);
            else     qa.push_back(rw ? 32'h0 : rexp);
        end
        @(posedge clk); #1;
        if (!keep) begin a_valid = 1'b0; b_valid = 1'b0; end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            v = sel ? vb : va;
            if (c == n) begin
                ectl = 5'b11110;
            end else begin
                h    = (c - 1) / (w + 2);
                p    = (c - 1) % (w + 2);
                strb = (p >= 1) && (p <= w);
                ectl = {1'b0, 1'b0, !(strb && !rw), !(strb && rw), rw};
                chk($sformatf("addr c%0d", c), 32'(v.addr), (base << 1) | 32'(h));
                if (rw) chk($sformatf("dq_o c%0d", c), 32'(v.dq), h ? 32'(wd[31:16]) : 32'(wd[15:0]));
            end
            chk($sformatf("ctl c%0d", c), 32'(v.ctl), 32'(ectl));
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
                @(negedge clk);
                v = sel ? vb : va;
                chk("abort_ctl", 32'(v.ctl), 32'(5'b01110));
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        a_valid = 1'b1; a_rw = 1'b1; a_addr_in = 32'h104; a_dtw = 32'h11112222;
        b_valid = 1'b1; b_rw = 1'b1; b_addr_in = 32'h8;   b_dtw = 32'h33334444;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // reset values, with i_valid asserted during reset
        chk("rst a_ctl",  32'(va.ctl), 32'(5'b01110));
        chk("rst a_addr", 32'(a_addr), 32'h0);
        chk("rst a_dq",   32'(a_dqo),  32'h0);
        chk("rst a_dtr",  a_dtr,       32'h0);
        chk("rst b_ctl",  32'(vb.ctl), 32'(5'b01110));
        chk("rst b_addr", 32'(b_addr), 32'h0);
        rst = 1'b0; mem_clr = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        // no transfer may start from a request seen only under reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst a_ctl", 32'(va.ctl), 32'(5'b01110));
            chk("post_rst b_ctl", 32'(vb.ctl), 32'(5'b01110));
        end
        @(posedge clk); #1;

        xfer(1'b0, 1'b1, 32'h00000104, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        xfer(1'b0, 1'b0, 32'h00000104, 32'h0,        32'hDEADBEEF, 1'b1, 0);
        xfer(1'b0, 1'b0, 32'h00000200, 32'h0,        32'hA101A100, 1'b0, 0);
        // abort in the second strobe cycle of the high half
        xfer(1'b0, 1'b1, 32'h00000300, 32'hCAFEF00D, 32'h0,        1'b0, 7);
        repeat (12) @(posedge clk);
        #1;
        xfer(1'b0, 1'b1, 32'h00000300, 32'h0BADF00D, 32'h0,        1'b0, 0);
        xfer(1'b0, 1'b0, 32'h00000300, 32'h0,        32'h0BADF00D, 1'b0, 0);
        xfer(1'b1, 1'b1, 32'hFFFF0008, 32'h12345678, 32'h0,        1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("qa_left", 32'(qa.size()), 32'd0);
        chk("qb_left", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
